// File: rtl/aes_pkg.sv
// Shared AES types, byte indexing helpers and the FIPS-197 inverse S-box table.
// Byte 0 of a state lives in bits [127:120], byte 15 in bits [7:0].
package aes_pkg;

  localparam int unsigned AES_NBYTES = 16;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  // Listed from entry 0x00 upward, so entry b sits at packed index 255 - b == ~b.
  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic aes_byte_t get_byte(input aes_state_t s, input int unsigned idx);
    return s[127 - 8 * idx -: 8];
  endfunction

  function automatic aes_state_t set_byte(input aes_state_t s, input int unsigned idx,
                                          input aes_byte_t b);
    aes_state_t r;
    r = s;
    r[127 - 8 * idx -: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup, one byte in, one byte out.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  assign byte_o = INV_SBOX[~byte_i];

endmodule

// File: rtl/sbox.sv
// Combinational AES forward S-box lookup, only built when INV_SUB_BYTES_FWD_EN is defined.
`ifdef INV_SUB_BYTES_FWD_EN
module sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // Listed from entry 0x00 upward, so entry b sits at packed index ~b.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign byte_o = SBOX[~byte_i];

endmodule
`endif

// File: rtl/inv_sub_bytes_seq.sv
// Sequential InvSubBytes engine: LANES bytes per cycle over a 128-bit state, valid/ready both sides.
// Define INV_SUB_BYTES_FWD_EN to add a fwd input that selects the forward S-box per job.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
`ifdef INV_SUB_BYTES_FWD_EN
  input  logic         fwd,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int unsigned NGROUPS = AES_NBYTES / LANES;
  localparam logic [3:0]  LastGrp = 4'(NGROUPS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            grp_q, grp_d;
  aes_state_t            work_q, work_d;
  logic [LANES-1:0][7:0] lane_in;
  logic [LANES-1:0][7:0] lane_out;

  always_comb begin
    lane_in = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_in[l] = get_byte(work_q, 32'(grp_q) * LANES + l);
    end
  end

`ifdef INV_SUB_BYTES_FWD_EN
  logic fwd_q, fwd_d;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] inv_b, fwd_b;
    inv_sbox u_inv_sbox (.byte_i(lane_in[l]), .byte_o(inv_b));
    sbox     u_sbox     (.byte_i(lane_in[l]), .byte_o(fwd_b));
    assign lane_out[l] = fwd_q ? fwd_b : inv_b;
  end
`else
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sbox u_inv_sbox (.byte_i(lane_in[l]), .byte_o(lane_out[l]));
  end
`endif

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    work_d  = work_q;
`ifdef INV_SUB_BYTES_FWD_EN
    fwd_d   = fwd_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StBusy;
          grp_d   = '0;
          work_d  = in_data;
`ifdef INV_SUB_BYTES_FWD_EN
          fwd_d   = fwd;
`endif
        end
      end
      StBusy: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          work_d = set_byte(work_d, 32'(grp_q) * LANES + l, lane_out[l]);
        end
        grp_d = grp_q + 4'd1;
        if (grp_q == LastGrp) begin
          state_d = StDone;
          grp_d   = '0;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over every transition, including an acceptance in IDLE.
    if (clear) begin
      state_d = StIdle;
      grp_d   = '0;
      work_d  = work_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grp_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      work_q  <= work_d;
    end
  end

`ifdef INV_SUB_BYTES_FWD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fwd_q <= 1'b0;
    else        fwd_q <= fwd_d;
  end
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Scoreboard bench for inv_sub_bytes_seq: directed blocks queued at acceptance, monitor compares.
module tb_inv_sub_bytes_seq;
  import aes_pkg::*;

  localparam int unsigned NG = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [127:0] out_data;
`ifdef INV_SUB_BYTES_FWD_EN
  logic         fwd = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sub_bytes_seq #(.LANES(NG)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
`ifdef INV_SUB_BYTES_FWD_EN
    .fwd      (fwd),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout required completion", name);
  endtask

  // Monitor: first cycle of each out_valid episode pops the scoreboard.
  logic         ov_prev = 1'b0;
  logic         hs_prev = 1'b0;
  logic [127:0] last = '0;
  exp_t         me;

  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) begin
        chk1("bubble_out_valid", out_valid, 1'b0);
        chk1("bubble_in_ready", in_ready, 1'b1);
      end
      if (out_valid) begin
        chk1("done_in_ready", in_ready, 1'b0);
        if (!ov_prev || hs_prev) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got data %h required no output", out_data);
          end else begin
            me = q.pop_front();
            chk("out_data", out_data, me.data);
            chki("latency", cyc - me.acc, NG);
          end
          last = out_data;
        end else begin
          chk("hold_data", out_data, last);
        end
      end
      ov_prev = out_valid;
      hs_prev = out_valid && out_ready;
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] e, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!(in_ready && !clear) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      timeout("accept");
      in_valid = 1'b0;
      return;
    end
    if (push) q.push_back('{data: e, acc: cyc + 1});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) timeout("drain");
    repeat (2) @(negedge clk);
  endtask

  // Extra instances cover the other lane counts with one block each.
  for (genvar k = 0; k < 4; k++) begin : g_sub
    localparam int unsigned L = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : 16;
    logic         iv = 1'b0;
    logic         ir, ov;
    logic [127:0] od;
    bit           done = 1'b0;
    int           sn;
    exp_t         sq[$];
    exp_t         se;

    inv_sub_bytes_seq #(.LANES(L)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (1'b0),
`ifdef INV_SUB_BYTES_FWD_EN
      .fwd      (1'b0),
`endif
      .in_valid (iv),
      .in_ready (ir),
      .in_data  (128'h637c777bf26b6fc53001672bfed7ab76),
      .out_valid(ov),
      .out_ready(1'b1),
      .out_data (od)
    );

    initial begin
      @(posedge rst_n);
      @(negedge clk);
      iv = 1'b1;
      sn = 0;
      while (!ir && sn < 50) begin
        @(negedge clk);
        sn++;
      end
      sq.push_back('{data: 128'h000102030405060708090a0b0c0d0e0f, acc: cyc + 1});
      @(posedge clk);
      #1 iv = 1'b0;
    end

    always @(negedge clk) begin
      if (rst_n && ov) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sub%0d_unexpected: got data %h required no output", L, od);
        end else begin
          se = sq.pop_front();
          chk($sformatf("sub%0d_data", L), od, se.data);
          chki($sformatf("sub%0d_latency", L), cyc - se.acc, 16 / L);
        end
        done = 1'b1;
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 128'h0);
    rst_n = 1'b1;

    send({16{8'h63}}, 128'h0, 1'b1);
    drain();
    send(128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    drain();
    send(128'h637c0016ed637c0016ed637c0016ed63, 128'h000152ff53000152ff53000152ff5300, 1'b1);
    drain();
    send(128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb, 1'b1);
    drain();

    // Back-pressure with a stray in_valid that must be ignored.
    out_ready = 1'b0;
    send({16{8'h16}}, {16{8'hff}}, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout("bp_out_valid");
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = {16{8'hed}};
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Abort at the second BUSY cycle; nothing may come out.
    send({16{8'h11}}, 128'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk1("clear_in_ready", in_ready, 1'b1);
    chk1("clear_out_valid", out_valid, 1'b0);
    repeat (8) @(negedge clk);

    // clear together with in_valid in IDLE must not accept.
    in_valid = 1'b1;
    in_data  = {16{8'h22}};
    clear    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    chk1("clear_accept_in_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);

    send({16{8'h00}}, {16{8'h52}}, 1'b1);
    drain();

    // Asynchronous reset in the middle of a job.
    send({16{8'h33}}, 128'h0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_in_ready", in_ready, 1'b1);
    chk1("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_out_data", out_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send({16{8'hed}}, {16{8'h53}}, 1'b1);
    drain();

`ifdef INV_SUB_BYTES_FWD_EN
    fwd = 1'b1;
    send(128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76, 1'b1);
    drain();
    fwd = 1'b0;
    send(128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb, 1'b1);
    drain();
`endif

    n = 0;
    while (!(g_sub[0].done && g_sub[1].done && g_sub[2].done && g_sub[3].done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(g_sub[0].done && g_sub[1].done && g_sub[2].done && g_sub[3].done)) timeout("sub_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
